// File: rtl/vga_sprite_gen.sv
// Pixel-colour generator for a VGA timing block: 1-pixel white border plus a
// bouncing solid square sprite whose colour steps on every bounce.
module vga_sprite_gen #(
  parameter int          H_ACTIVE = 640,
  parameter int          V_ACTIVE = 480,
  parameter int          BOX_SIZE = 32,
  parameter int          STEP     = 2,
  parameter logic [2:0]  BG_RGB   = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic       video_on,
  input  logic       pause,
  output logic       red,
  output logic       green,
  output logic       blue,
  output logic       frame_tick,
  output logic       bounce
);

  localparam logic [10:0] H_A    = 11'(H_ACTIVE);
  localparam logic [10:0] V_A    = 11'(V_ACTIVE);
  localparam logic [10:0] BOX    = 11'(BOX_SIZE);
  localparam logic [10:0] BOX_M1 = 11'(BOX_SIZE - 1);
  localparam logic [10:0] STP    = 11'(STEP);

  typedef enum logic {DIR_POS, DIR_NEG} dir_e;

  typedef struct packed {
    logic [9:0] pos;
    dir_e       dir;
    logic       hit;
  } axis_t;

  // One axis of motion; limit is the visible extent of that axis.
  function automatic axis_t step_axis(input logic [9:0] pos, input dir_e dir,
                                      input logic [10:0] limit);
    axis_t      r;
    logic [10:0] p;
    p     = {1'b0, pos};
    r.pos = pos;
    r.dir = dir;
    r.hit = 1'b0;
    if (dir == DIR_POS) begin
      if (p + STP + BOX >= limit) begin
        r.pos = 10'(limit - BOX);
        r.dir = DIR_NEG;
        r.hit = 1'b1;
      end else begin
        r.pos = 10'(p + STP);
      end
    end else begin
      if (p <= STP) begin
        r.pos = 10'd0;
        r.dir = DIR_POS;
        r.hit = 1'b1;
      end else begin
        r.pos = 10'(p - STP);
      end
    end
    return r;
  endfunction

  function automatic logic [2:0] next_colour(input logic [2:0] c);
    case (c)
      3'b100:  return 3'b010;
      3'b010:  return 3'b001;
      3'b001:  return 3'b110;
      3'b110:  return 3'b011;
      3'b011:  return 3'b101;
      3'b101:  return 3'b111;
      default: return 3'b100;
    endcase
  endfunction

  logic [9:0] box_x_q, box_x_d, box_y_q, box_y_d;
  dir_e       dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic [2:0] colour_q, colour_d, rgb_q, rgb_d;
  logic       sof_q, sof_d, armed_q, armed_d;
  logic       frame_tick_q, frame_tick_d, bounce_q, bounce_d;

  logic       sof_cond, border, in_box;
  logic [10:0] px, py;
  axis_t      ax, ay;

  assign px       = {1'b0, pixel_x};
  assign py       = {1'b0, pixel_y};
  assign sof_cond = (py == V_A) && (pixel_x == 10'd0);
  assign border   = (pixel_x == 10'd0) || (px == H_A - 11'd1) ||
                    (pixel_y == 10'd0) || (py == V_A - 11'd1);
  assign in_box   = (px >= {1'b0, box_x_q}) && (px <= {1'b0, box_x_q} + BOX_M1) &&
                    (py >= {1'b0, box_y_q}) && (py <= {1'b0, box_y_q} + BOX_M1);
  assign ax       = step_axis(box_x_q, dir_x_q, H_A);
  assign ay       = step_axis(box_y_q, dir_y_q, V_A);

  always_comb begin
    box_x_d  = box_x_q;
    box_y_d  = box_y_q;
    dir_x_d  = dir_x_q;
    dir_y_d  = dir_y_q;
    colour_d = colour_q;
    bounce_d = 1'b0;
    sof_d    = sof_cond;
    // armed_q stays low until sof_cond has been seen low, so a level that is
    // already high when reset releases is not mistaken for an edge.
    armed_d      = armed_q | ~sof_cond;
    frame_tick_d = sof_cond & ~sof_q & armed_q;

    if (frame_tick_q && !pause) begin
      box_x_d  = ax.pos;
      box_y_d  = ay.pos;
      dir_x_d  = ax.dir;
      dir_y_d  = ay.dir;
      bounce_d = ax.hit | ay.hit;
      if (ax.hit || ay.hit) colour_d = next_colour(colour_q);
    end

    if (!video_on)   rgb_d = 3'b000;
    else if (border) rgb_d = 3'b111;
    else if (in_box) rgb_d = colour_q;
    else             rgb_d = BG_RGB;
  end

  // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      box_x_q      <= 10'd0;
      box_y_q      <= 10'd0;
      dir_x_q      <= DIR_POS;
      dir_y_q      <= DIR_POS;
      colour_q     <= 3'b100;
      rgb_q        <= 3'b000;
      sof_q        <= 1'b0;
      armed_q      <= 1'b0;
      frame_tick_q <= 1'b0;
      bounce_q     <= 1'b0;
    end else begin
      box_x_q      <= box_x_d;
      box_y_q      <= box_y_d;
      dir_x_q      <= dir_x_d;
      dir_y_q      <= dir_y_d;
      colour_q     <= colour_d;
      rgb_q        <= rgb_d;
      sof_q        <= sof_d;
      armed_q      <= armed_d;
      frame_tick_q <= frame_tick_d;
      bounce_q     <= bounce_d;
    end
  end

  assign {red, green, blue} = rgb_q;
  assign frame_tick         = frame_tick_q;
  assign bounce             = bounce_q;

endmodule

// File: tb/tb_vga_sprite_gen.sv
// Directed bench for vga_sprite_gen: 640x480 instance plus a 480x480 instance
// whose axes bounce on the same tick.
module tb_vga_sprite_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] pixel_x, pixel_y;
  logic       video_on, pause;
  logic       red, green, blue, frame_tick, bounce;
  logic       red_sq, green_sq, blue_sq, frame_tick_sq, bounce_sq;
  logic [2:0] rgb;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;
  assign rgb = {red, green, blue};

  vga_sprite_gen dut (
    .clk(clk), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .video_on(video_on), .pause(pause), .red(red), .green(green), .blue(blue),
    .frame_tick(frame_tick), .bounce(bounce)
  );

  vga_sprite_gen #(.H_ACTIVE(480), .V_ACTIVE(480)) dut_sq (
    .clk(clk), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .video_on(video_on), .pause(pause), .red(red_sq), .green(green_sq),
    .blue(blue_sq), .frame_tick(frame_tick_sq), .bounce(bounce_sq)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One frame-start event: sof_cond held for `hold` clks, then a few idle clks.
  task automatic do_tick(input int hold, output int ft, output int bn, output int bn_sq);
    ft = 0; bn = 0; bn_sq = 0;
    video_on = 1'b0;
    pixel_x  = 10'd0;
    pixel_y  = 10'd480;
    for (int i = 0; i < hold + 3; i++) begin
      if (i == hold) pixel_y = 10'd5;
      step();
      ft    += int'(frame_tick);
      bn    += int'(bounce);
      bn_sq += int'(bounce_sq);
    end
  endtask

  task automatic run_ticks(input int n, output int ft, output int bn, output int bn_sq);
    int f, b, bs;
    ft = 0; bn = 0; bn_sq = 0;
    for (int i = 0; i < n; i++) begin
      do_tick(1, f, b, bs);
      ft += f; bn += b; bn_sq += bs;
    end
  endtask

  task automatic pix(input int x, input int y, input logic von);
    pixel_x  = 10'(x);
    pixel_y  = 10'(y);
    video_on = von;
    step();
  endtask

  initial begin
    int ft, bn, bs, exp;
    reset = 1'b1; pause = 1'b0; video_on = 1'b0;
    pixel_x = 10'd0; pixel_y = 10'd10;
    #1;
    check("rst_rgb", int'(rgb), 0);
    check("rst_tick", int'(frame_tick), 0);
    check("rst_bounce", int'(bounce), 0);
    check("rst_box_x", int'(dut.box_x_q), 0);
    check("rst_box_y", int'(dut.box_y_q), 0);
    check("rst_colour", int'(dut.colour_q), 4);
    step(); step();
    reset = 1'b0;
    step();

    // Line 10 sweep with the sprite at the origin.
    for (int x = 0; x < 640; x++) begin
      pix(x, 10, 1'b1);
      exp = (x == 0 || x == 639) ? 7 : (x <= 31) ? 4 : 0;
      check($sformatf("sweep_x%0d", x), int'(rgb), exp);
    end
    pix(100, 0, 1'b1);   check("top_border", int'(rgb), 7);
    pix(100, 479, 1'b1); check("bot_border", int'(rgb), 7);
    pix(10, 10, 1'b0);   check("blank", int'(rgb), 0);

    // First tick, sof_cond held 4 clks.
    do_tick(4, ft, bn, bs);
    check("t1_ticks", ft, 1);
    check("t1_bounce", bn, 0);
    check("t1_box_x", int'(dut.box_x_q), 2);
    check("t1_box_y", int'(dut.box_y_q), 2);

    // Ticks 2..223: no bounce yet, y reaches 446.
    run_ticks(222, ft, bn, bs);
    check("t223_ticks", ft, 222);
    check("t223_bounce", bn, 0);
    check("t223_box_y", int'(dut.box_y_q), 446);
    check("sq_t223_bounce", bs, 0);

    // Tick 224: y bounces on main; both axes bounce together on the square one.
    do_tick(1, ft, bn, bs);
    check("t224_bounce", bn, 1);
    check("t224_box_x", int'(dut.box_x_q), 448);
    check("t224_box_y", int'(dut.box_y_q), 448);
    check("t224_colour", int'(dut.colour_q), 2);
    check("sq_corner_bounce", bs, 1);
    check("sq_corner_x", int'(dut_sq.box_x_q), 448);
    check("sq_corner_y", int'(dut_sq.box_y_q), 448);
    check("sq_corner_colour", int'(dut_sq.colour_q), 2);
    do_tick(1, ft, bn, bs);
    check("sq_after_x", int'(dut_sq.box_x_q), 446);
    check("sq_after_y", int'(dut_sq.box_y_q), 446);
    check("sq_after_bounce", bs, 0);

    // Ticks 226..303: x climbs to 606 while y descends.
    run_ticks(78, ft, bn, bs);
    check("t303_bounce", bn, 0);
    check("t303_box_x", int'(dut.box_x_q), 606);
    check("t303_box_y", int'(dut.box_y_q), 290);
    do_tick(1, ft, bn, bs);
    check("t304_bounce", bn, 1);
    check("t304_box_x", int'(dut.box_x_q), 608);
    check("t304_box_y", int'(dut.box_y_q), 288);
    check("t304_colour", int'(dut.colour_q), 1);
    do_tick(1, ft, bn, bs);
    check("t305_bounce", bn, 0);
    check("t305_box_x", int'(dut.box_x_q), 606);
    check("t305_box_y", int'(dut.box_y_q), 286);

    // Pause across three ticks.
    pause = 1'b1;
    run_ticks(3, ft, bn, bs);
    pause = 1'b0;
    check("pause_ticks", ft, 3);
    check("pause_bounce", bn, 0);
    check("pause_box_x", int'(dut.box_x_q), 606);
    check("pause_box_y", int'(dut.box_y_q), 286);
    check("pause_colour", int'(dut.colour_q), 1);

    // Sprite edges at box (606,286), colour 001.
    pix(605, 300, 1'b1); check("box_left_out", int'(rgb), 0);
    pix(606, 300, 1'b1); check("box_left_in", int'(rgb), 1);
    pix(637, 300, 1'b1); check("box_right_in", int'(rgb), 1);
    pix(638, 300, 1'b1); check("box_right_out", int'(rgb), 0);
    pix(610, 286, 1'b1); check("box_top_in", int'(rgb), 1);
    pix(610, 285, 1'b1); check("box_top_out", int'(rgb), 0);
    pix(610, 317, 1'b1); check("box_bot_in", int'(rgb), 1);
    pix(610, 318, 1'b1); check("box_bot_out", int'(rgb), 0);
    pix(639, 300, 1'b1); check("border_over_box", int'(rgb), 7);
    pix(610, 300, 1'b0); check("blank_over_box", int'(rgb), 0);

    // Mid-line reset inside the box.
    pix(610, 300, 1'b1); check("pre_rst_rgb", int'(rgb), 1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_rgb", int'(rgb), 0);
    check("mid_rst_box_x", int'(dut.box_x_q), 0);
    check("mid_rst_box_y", int'(dut.box_y_q), 0);
    check("mid_rst_colour", int'(dut.colour_q), 4);
    pix(300, 200, 1'b0); check("rst_blank_rgb", int'(rgb), 0);

    // Release with sof_cond already high: no tick until a fresh rising edge.
    pixel_x = 10'd0; pixel_y = 10'd480; video_on = 1'b0;
    step();
    reset = 1'b0;
    ft = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      ft += int'(frame_tick);
    end
    check("release_high_ticks", ft, 0);
    pixel_y = 10'd5;
    step();
    ft = 0;
    pixel_y = 10'd480;
    for (int i = 0; i < 4; i++) begin
      step();
      ft += int'(frame_tick);
    end
    check("fresh_edge_ticks", ft, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
